// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared widths, requester ids and lock states for regfile_arbiter
//   DEF_DW / DEF_AW : default data / address widths of the 8x16 regfile
//   req_id_e        : requester identifiers (CPU control FSM, debug/loader)
//   lock_state_e    : ownership-lock FSM states (used with REGFILE_ARB_LOCK_EN)
package regfile_arb_pkg;
    localparam int DEF_DW = 16;
    localparam int DEF_AW = 3;
    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCK0    = 2'd1,
        LOCK1    = 2'd2
    } lock_state_e;
endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick, one-hot grant
//   req_i  : requests from requester 0 (bit 0) and 1 (bit 1)
//   last_i : id granted most recently; the other id wins a tie
//   mask_i : requests blocked by the lock FSM
//   gnt_o  : one-hot (or zero) grant
module rr_arb2
    import regfile_arb_pkg::*;
(
    input  logic    [1:0] req_i,
    input  req_id_e       last_i,
    input  logic    [1:0] mask_i,
    output logic    [1:0] gnt_o
);
    logic [1:0] r;
    always_comb begin
        r        = req_i & ~mask_i;
        gnt_o[0] = r[0] & (~r[1] | (last_i == REQ_DBG));
        gnt_o[1] = r[1] & (~r[0] | (last_i == REQ_CPU));
    end
endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin sharing of the regfile read/write ports by two requesters
//   clk, reset              : clock, synchronous active-high reset
//   req*/we*/addr*/wdata*   : requester transactions, held until granted
//   gnt*                    : combinational grant
//   rvalid*/rdata*          : registered read data, rvalid pulses the cycle after gnt
//   lock*                   : ownership hold, only when REGFILE_ARB_LOCK_EN is defined
//   rf_*                    : control/data connections to the regfile instance
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          rf_write,
    output logic [AW-1:0] rf_writenum,
    output logic [AW-1:0] rf_readnum,
    output logic [DW-1:0] rf_data_in,
    input  logic [DW-1:0] rf_data_out
);
    req_id_e       last_q, last_d;
    logic [1:0]    arb_gnt, gnt, mask, rd, rvalid_q;
    logic [DW-1:0] rdata0_q, rdata1_q, wdata;
    logic [AW-1:0] addr;
    logic          we, any;

    rr_arb2 u_rr (
        .req_i  ({req1, req0}),
        .last_i (last_q),
        .mask_i (mask),
        .gnt_o  (arb_gnt)
    );

    always_comb begin
        gnt         = reset ? 2'b00 : arb_gnt;
        any         = |gnt;
        we          = gnt[1] ? we1 : we0;
        addr        = gnt[1] ? addr1 : addr0;
        wdata       = gnt[1] ? wdata1 : wdata0;
        rf_write    = any & we;
        rf_writenum = rf_write ? addr : '0;
        rf_data_in  = rf_write ? wdata : '0;
        rf_readnum  = (any & ~we) ? addr : '0;
        rd          = gnt & ~{we1, we0};
        last_d      = gnt[1] ? REQ_DBG : gnt[0] ? REQ_CPU : last_q;
    end

`ifdef REGFILE_ARB_LOCK_EN
    lock_state_e lock_q, lock_d;
    // A held lock only releases on its own lock bit, regardless of grants.
    always_comb begin
        mask   = (lock_q == LOCK0) ? 2'b10 : (lock_q == LOCK1) ? 2'b01 : 2'b00;
        lock_d = (lock_q == LOCK0) ? (lock0 ? LOCK0 : UNLOCKED) :
                 (lock_q == LOCK1) ? (lock1 ? LOCK1 : UNLOCKED) :
                 (gnt[0] & lock0)  ? LOCK0 :
                 (gnt[1] & lock1)  ? LOCK1 : UNLOCKED;
    end
    always_ff @(posedge clk) lock_q <= reset ? UNLOCKED : lock_d;
`else
    assign mask = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q   <= REQ_DBG;
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            last_q   <= last_d;
            rvalid_q <= rd;
            if (rd[0]) rdata0_q <= rf_data_out;
            if (rd[1]) rdata1_q <= rf_data_out;
        end
    end

    assign gnt0    = gnt[0];
    assign gnt1    = gnt[1];
    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
endmodule
